// File: rtl/pwm_cfg_sequencer.sv
// pwm_cfg_sequencer: register bank and commit/ramp sequencer that feeds step and
// interval values to a PWM generator.
// Latency: register writes take effect on the next edge; reg_rdata is valid one cycle after reg_rd.
// Backpressure: none; the strobes are one-cycle and always accepted, and period_tick is consumed when relevant.
// Ports:
//   clock, resetn (sync, active-low)
//   reg_wr/reg_rd/reg_addr/reg_wdata/reg_rdata : register access from the I2C slave
//   period_tick                                : period boundary pulse from the PWM generator
//   clock_step, fb_interval, pwm_en, busy      : outputs to the PWM generator and status
module pwm_cfg_sequencer #(
  parameter logic [15:0] RESET_STEP     = 16'd65535,
  parameter logic [15:0] RESET_INTERVAL = 16'd96,
  parameter logic [7:0]  RESET_RAMP_INC = 8'd1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [7:0]  reg_addr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  input  logic        period_tick,
  output logic [15:0] clock_step,
  output logic [15:0] fb_interval,
  output logic        pwm_en,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_RAMP    = 2'd2;

  logic [15:0] shadow_step_q, shadow_step_d;
  logic [15:0] shadow_int_q,  shadow_int_d;
  logic [15:0] target_step_q, target_step_d;
  logic [15:0] target_int_q,  target_int_d;
  logic [15:0] clock_step_q,  clock_step_d;
  logic [15:0] fb_interval_q, fb_interval_d;
  logic [7:0]  ramp_inc_q,    ramp_inc_d;
  logic        enable_q,      enable_d;
  logic        ramp_en_q,     ramp_en_d;
  logic [1:0]  state_q,       state_d;
  logic [7:0]  rdata_q,       rdata_d;

  logic        ctrl_wr;
  logic        commit;
  logic [15:0] eff_inc;
  logic [15:0] diff;
  logic        step_up;
  logic        step_done;
  logic [15:0] step_next;

  assign ctrl_wr = reg_wr && (reg_addr == 8'h04);
  assign commit  = ctrl_wr && reg_wdata[1];

  // One ramp step toward the target. A zero increment would stall the ramp, so it acts as 1.
  // When the remaining distance fits in one step we land exactly on the target, which also
  // rules out wrapping past 0 or 0xFFFF.
  assign eff_inc   = (ramp_inc_q == 8'd0) ? 16'd1 : {8'd0, ramp_inc_q};
  assign step_up   = target_step_q > clock_step_q;
  assign diff      = step_up ? (target_step_q - clock_step_q) : (clock_step_q - target_step_q);
  assign step_done = diff <= eff_inc;
  assign step_next = step_done ? target_step_q :
                     (step_up ? (clock_step_q + eff_inc) : (clock_step_q - eff_inc));

  always_comb begin
    shadow_step_d = shadow_step_q;
    shadow_int_d  = shadow_int_q;
    target_step_d = target_step_q;
    target_int_d  = target_int_q;
    clock_step_d  = clock_step_q;
    fb_interval_d = fb_interval_q;
    ramp_inc_d    = ramp_inc_q;
    enable_d      = enable_q;
    ramp_en_d     = ramp_en_q;
    state_d       = state_q;
    rdata_d       = rdata_q;

    if (reg_wr) begin
      case (reg_addr)
        8'h00: shadow_step_d[7:0]  = reg_wdata;
        8'h01: shadow_step_d[15:8] = reg_wdata;
        8'h02: shadow_int_d[7:0]   = reg_wdata;
        8'h03: shadow_int_d[15:8]  = reg_wdata;
        8'h04: begin
          enable_d  = reg_wdata[0];
          ramp_en_d = reg_wdata[2];
        end
        8'h05: ramp_inc_d = reg_wdata;
        default: ;
      endcase
    end

    if (reg_rd) begin
      case (reg_addr)
        8'h00: rdata_d = shadow_step_q[7:0];
        8'h01: rdata_d = shadow_step_q[15:8];
        8'h02: rdata_d = shadow_int_q[7:0];
        8'h03: rdata_d = shadow_int_q[15:8];
        8'h04: rdata_d = {5'd0, ramp_en_q, 1'b0, enable_q};
        8'h05: rdata_d = ramp_inc_q;
        8'h06: rdata_d = {5'd0, state_q == ST_PENDING, enable_q, state_q != ST_IDLE};
        default: rdata_d = 8'h00;
      endcase
    end

    // Commit outranks a same-cycle tick; a disable write outranks it as well.
    if (commit) begin
      target_step_d = shadow_step_q;
      target_int_d  = shadow_int_q;
      if (reg_wdata[0]) begin
        state_d = ST_PENDING;
      end else begin
        clock_step_d  = shadow_step_q;
        fb_interval_d = shadow_int_q;
        state_d       = ST_IDLE;
      end
    end else if (ctrl_wr && !reg_wdata[0] && (state_q != ST_IDLE)) begin
      clock_step_d  = target_step_q;
      fb_interval_d = target_int_q;
      state_d       = ST_IDLE;
    end else if (period_tick) begin
      case (state_q)
        ST_PENDING: begin
          fb_interval_d = target_int_q;
          // The tick that leaves PENDING also takes the first ramp step.
          if (ramp_en_q && (clock_step_q != target_step_q)) begin
            clock_step_d = step_next;
            state_d      = step_done ? ST_IDLE : ST_RAMP;
          end else begin
            clock_step_d = target_step_q;
            state_d      = ST_IDLE;
          end
        end
        ST_RAMP: begin
          clock_step_d = step_next;
          state_d      = step_done ? ST_IDLE : ST_RAMP;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      shadow_step_q <= RESET_STEP;
      shadow_int_q  <= RESET_INTERVAL;
      target_step_q <= RESET_STEP;
      target_int_q  <= RESET_INTERVAL;
      clock_step_q  <= RESET_STEP;
      fb_interval_q <= RESET_INTERVAL;
      ramp_inc_q    <= RESET_RAMP_INC;
      enable_q      <= 1'b0;
      ramp_en_q     <= 1'b0;
      state_q       <= ST_IDLE;
      rdata_q       <= 8'h00;
    end else begin
      shadow_step_q <= shadow_step_d;
      shadow_int_q  <= shadow_int_d;
      target_step_q <= target_step_d;
      target_int_q  <= target_int_d;
      clock_step_q  <= clock_step_d;
      fb_interval_q <= fb_interval_d;
      ramp_inc_q    <= ramp_inc_d;
      enable_q      <= enable_d;
      ramp_en_q     <= ramp_en_d;
      state_q       <= state_d;
      rdata_q       <= rdata_d;
    end
  end

  assign reg_rdata   = rdata_q;
  assign clock_step  = clock_step_q;
  assign fb_interval = fb_interval_q;
  assign pwm_en      = enable_q;
  assign busy        = state_q != ST_IDLE;

endmodule

// File: doc/pwm_cfg_sequencer.md
PWM_CFG_SEQUENCER -- requirements
Module: pwm_cfg_sequencer

Interface
REQ-001 SHALL have parameter RESET_STEP, default 65535: clock_step value after reset.
REQ-002 SHALL have parameter RESET_INTERVAL, default 96: fb_interval value after reset.
REQ-003 SHALL have parameter RESET_RAMP_INC, default 1: RAMP_INC register value after reset.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic is sampled on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port reg_wr, input, 1 bit: one-cycle register write strobe from the I2C slave.
REQ-007 SHALL have port reg_rd, input, 1 bit: one-cycle register read strobe.
REQ-008 SHALL have port reg_addr, input, 8 bits: register address.
REQ-009 SHALL have port reg_wdata, input, 8 bits: write data.
REQ-010 SHALL have port reg_rdata, output, 8 bits: read data.
REQ-011 SHALL have port period_tick, input, 1 bit: one-cycle pulse from the PWM generator at each period boundary.
REQ-012 SHALL have port clock_step, output, 16 bits: step value driven to the PWM generator.
REQ-013 SHALL have port fb_interval, output, 16 bits: feedback interval driven to the PWM generator.
REQ-014 SHALL have port pwm_en, output, 1 bit: PWM generator enable.
REQ-015 SHALL have port busy, output, 1 bit: high while the FSM is not IDLE.

Function
REQ-016 SHALL implement this register map:
- 0x00 STEP_L, 0x01 STEP_H: shadow step, read/write.
- 0x02 INT_L, 0x03 INT_H: shadow interval, read/write.
- 0x04 CTRL: bit0 ENABLE, bit1 COMMIT (write-only, reads 0), bit2 RAMP_EN.
- 0x05 RAMP_INC: read/write.
- 0x06 STATUS, read-only: bit0 busy, bit1 pwm_en, bit2 pending (state==PENDING).
REQ-017 SHALL ignore writes to unmapped or read-only addresses, and SHALL return 0x00 when they are read.
REQ-018 SHALL update reg_rdata on the cycle after reg_rd; reg_rdata holds its value otherwise.
REQ-019 SHALL never change clock_step or fb_interval as a direct result of writes to the shadow registers; only a commit (or a disable) moves values to the outputs.
REQ-020 SHALL drive pwm_en equal to CTRL.ENABLE, registered, so it changes one cycle after the CTRL write.
REQ-021 SHALL, on a write to CTRL with bit1=1 (commit), copy the shadow step and interval into target_step and target_int in that cycle.
REQ-022 SHALL implement an FSM with three states: IDLE, PENDING and RAMP.
REQ-023 SHALL, on a commit while ENABLE=0 (after the same write takes effect), load clock_step=target_step and fb_interval=target_int on the next cycle, and enter or remain in IDLE.
REQ-024 SHALL, on a commit while ENABLE=1, enter PENDING from any state, with the targets replaced by the new commit.
REQ-025 SHALL, in PENDING on period_tick, load fb_interval=target_int, then:
- if RAMP_EN=1 and clock_step≠target_step, enter RAMP;
- otherwise load clock_step=target_step and enter IDLE.
REQ-026 SHALL, in RAMP on each period_tick, move clock_step toward target_step by the effective increment (RAMP_INC, with RAMP_INC=0 treated as 1), in both directions, with no overflow or underflow.
REQ-027 SHALL, in RAMP, when |target_step−clock_step| ≤ the effective increment, load clock_step=target_step and enter IDLE.
REQ-028 SHALL, when a commit and a period_tick occur in the same cycle, give the commit priority; the tick is ignored for that cycle.
REQ-029 SHALL, when CTRL is written with ENABLE=0 while in PENDING or RAMP, abort the sequence: on the next cycle clock_step=target_step, fb_interval=target_int, and the FSM is IDLE.
REQ-030 SHALL ignore period_tick while in IDLE.
REQ-031 SHALL drive busy=1 exactly when the state is PENDING or RAMP.

Reset
REQ-032 SHALL, with resetn=0 at a rising clock edge, set:
- clock_step=RESET_STEP, fb_interval=RESET_INTERVAL;
- shadow and target registers to the same values;
- RAMP_INC=RESET_RAMP_INC, CTRL=0;
- pwm_en=0, busy=0, reg_rdata=0x00, FSM=IDLE.
REQ-033 SHALL give resetn priority over every other input; an assertion mid-ramp aborts the ramp in that cycle.

Verification
REQ-034 Disabled commit: write STEP=0x1234, INT=0x0200, then CTRL=0x02 -> clock_step=0x1234 and fb_interval=0x0200 one cycle later; busy stays 0.
REQ-035 Enabled, no ramp: CTRL=0x01, write STEP=0x0100, CTRL=0x03 -> busy=1 and outputs unchanged until period_tick; clock_step=0x0100 on the cycle after the tick; busy=0.
REQ-036 Ramp down: clock_step=0x0010, RAMP_INC=4, target 0x0006, CTRL=0x07 -> ticks give 0x000C, 0x0008, 0x0006; IDLE after the third tick.
REQ-037 Retarget mid-ramp: during a ramp toward 0x0100, commit 0x0000 -> PENDING; ramp resumes downward from the current value on the next tick.
REQ-038 Simultaneous commit and tick, plus disable abort: the tick is ignored and the state is PENDING; a CTRL=0x00 write in RAMP -> clock_step=target and busy=0 one cycle later.
REQ-039 Reset and readback: assert resetn=0 mid-ramp -> clock_step=65535, fb_interval=96; reg_rd at 0x05 returns 0x01; reg_rd at 0x07 returns 0x00.
